// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline control: MDU state encoding,
// default MDU latencies and the exception handler address.
package cpu_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam int MULT_LAT_DEFAULT = 5;
    localparam int DIV_LAT_DEFAULT  = 10;
    localparam int CNT_W_DEFAULT    = 4;

    localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;

    // Busy-cycle count to load for an MDU issue of the given kind.
    function automatic int md_latency(input logic is_div, input int mult_lat, input int div_lat);
        return is_div ? div_lat : mult_lat;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// MDU occupancy tracker: a RUN/BUSY FSM with a countdown of remaining busy
// cycles. md_busy also covers the issue cycle itself.
module md_busy_counter
    import cpu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic             md_is_div,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt
);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(md_latency(1'b0, MULT_LAT, DIV_LAT));
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(md_latency(1'b1, MULT_LAT, DIV_LAT));
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (md_start) begin
                    cnt_d   = md_is_div ? DIV_CNT : MULT_CNT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A new md_start cannot legally arrive here; it is ignored.
                if (cnt_q <= ONE_CNT) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - ONE_CNT;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = RUN;
            end
        endcase
    end

    assign md_busy = (state_q == BUSY) | md_start;
    assign md_cnt  = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use / MDU stalls, the global flush
// strobe Req for exceptions and eret, and next-PC select for the handler/EPC.
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int DIV_LAT  = DIV_LAT_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hazard_lu,
    input  logic             md_start,
    input  logic             md_is_div,
    input  logic             md_use_D,
    input  logic             exc_req,
    input  logic             eret_M,
    output logic             Req,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             exc_pc_sel,
    output logic             eret_pc_sel,
    output logic             epc_we,
    output logic             md_busy,
    output logic [CNT_W-1:0] md_cnt
);

    logic stall;

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_cnt (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_busy   (md_busy),
        .md_cnt    (md_cnt)
    );

    assign stall = hazard_lu | (md_busy & md_use_D);

    // A flush wipes every stage register anyway, so it overrides any stall.
    assign Req    = exc_req | eret_M;
    assign StallF = stall & ~Req;
    assign StallD = stall & ~Req;
    assign FlushE = stall & ~Req;

    assign exc_pc_sel  = exc_req;
    assign epc_we      = exc_req;
    assign eret_pc_sel = eret_M & ~exc_req;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       hazard_lu, md_start, md_is_div, md_use_D, exc_req, eret_M;
    logic       Req, StallF, StallD, FlushE, exc_pc_sel, eret_pc_sel, epc_we, md_busy;
    logic [3:0] md_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [11:0] obs, exp_v;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .hazard_lu   (hazard_lu),
        .md_start    (md_start),
        .md_is_div   (md_is_div),
        .md_use_D    (md_use_D),
        .exc_req     (exc_req),
        .eret_M      (eret_M),
        .Req         (Req),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushE      (FlushE),
        .exc_pc_sel  (exc_pc_sel),
        .eret_pc_sel (eret_pc_sel),
        .epc_we      (epc_we),
        .md_busy     (md_busy),
        .md_cnt      (md_cnt)
    );

    assign obs = {Req, StallF, StallD, FlushE, exc_pc_sel, eret_pc_sel, epc_we, md_busy, md_cnt};

    function automatic logic [11:0] ev(input bit rq, input bit st, input bit es, input bit ers,
                                       input bit we, input bit bz, input logic [3:0] c);
        return {rq, st, st, st, es, ers, we, bz, c};
    endfunction

    // Apply inputs on the falling edge, then let combinational outputs settle.
    task automatic drive(input bit hlu, input bit st, input bit dv, input bit use_d,
                         input bit ex, input bit er);
        @(negedge clk);
        hazard_lu = hlu; md_start = st; md_is_div = dv;
        md_use_D = use_d; exc_req = ex; eret_M = er;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tests_run++;
            if (md_cnt !== 4'd0 || md_busy !== md_start) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: md_cnt=%0d md_busy=%b, required md_cnt=0 md_busy=%b",
                         i, md_cnt, md_busy, md_start);
            end
        end
        @(negedge clk);
        hazard_lu = 0; md_start = 0; md_is_div = 0; md_use_D = 0; exc_req = 0; eret_M = 0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            tests_run++;
            if (obs !== 12'h000) begin
                tests_failed++;
                $display("FAIL reset_idle[%0d]: outputs=%h required=%h", i, obs, 12'h000);
            end
        end
    endtask

    task automatic test_mult();
        for (int c = 0; c <= 6; c++) begin
            drive(0, c == 0, 0, 1, 0, 0);
            exp_v = ev(0, c <= 5, 0, 0, 0, c <= 5, (c >= 1 && c <= 5) ? 4'(6 - c) : 4'd0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL mult_cycle%0d: outputs=%h required=%h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_div();
        for (int c = 0; c <= 11; c++) begin
            drive(0, c == 0, 1, c >= 4, 0, 0);
            exp_v = ev(0, c >= 4 && c <= 10, 0, 0, 0, c <= 10,
                       (c >= 1 && c <= 10) ? 4'(11 - c) : 4'd0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL div_cycle%0d: outputs=%h required=%h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_exc_busy();
        for (int c = 0; c <= 6; c++) begin
            drive(0, c == 0, 0, 1, c == 3, 0);
            exp_v = ev(c == 3, c <= 5 && c != 3, c == 3, 0, c == 3, c <= 5,
                       (c >= 1 && c <= 5) ? 4'(6 - c) : 4'd0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL exc_busy_cycle%0d: outputs=%h required=%h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_priority();
        drive(0, 0, 0, 0, 1, 1);
        tests_run++;
        if (obs !== ev(1, 0, 1, 0, 1, 0, 0)) begin
            tests_failed++;
            $display("FAIL prio_exc_eret: outputs=%h required=%h", obs, ev(1, 0, 1, 0, 1, 0, 0));
        end
        drive(0, 0, 0, 0, 0, 1);
        tests_run++;
        if (obs !== ev(1, 0, 0, 1, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL prio_eret_only: outputs=%h required=%h", obs, ev(1, 0, 0, 1, 0, 0, 0));
        end
        drive(1, 0, 0, 0, 0, 0);
        tests_run++;
        if (obs !== ev(0, 1, 0, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL load_use: outputs=%h required=%h", obs, ev(0, 1, 0, 0, 0, 0, 0));
        end
        drive(1, 0, 0, 0, 1, 0);
        tests_run++;
        if (obs !== ev(1, 0, 1, 0, 1, 0, 0)) begin
            tests_failed++;
            $display("FAIL load_use_vs_exc: outputs=%h required=%h", obs, ev(1, 0, 1, 0, 1, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        // md_start together with exc_req still loads; a second md_start while busy is ignored.
        for (int c = 0; c <= 6; c++) begin
            drive(0, c == 0 || c == 2, c == 2, 0, c == 0, 0);
            exp_v = ev(c == 0, 0, c == 0, 0, c == 0, c <= 5,
                       (c >= 1 && c <= 5) ? 4'(6 - c) : 4'd0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL start_exc_cycle%0d: outputs=%h required=%h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c <= 5; c++) begin
            drive(0, c == 0, 1, 0, 0, 0);
        end
        tests_run++;
        if (md_cnt !== 4'd6) begin
            tests_failed++;
            $display("FAIL rstmid_pre: md_cnt=%0d required=6", md_cnt);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (md_cnt !== 4'd0 || md_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_async: md_cnt=%0d md_busy=%b required 0/0", md_cnt, md_busy);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            drive(0, c == 0, 0, 0, 0, 0);
            exp_v = ev(0, 0, 0, 0, 0, c <= 5, (c >= 1 && c <= 5) ? 4'(6 - c) : 4'd0);
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL rstmid_mult_cycle%0d: outputs=%h required=%h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        hazard_lu = 0; md_start = 0; md_is_div = 0; md_use_D = 0; exc_req = 0; eret_M = 0;
        test_reset();
        test_mult();
        test_div();
        test_exc_busy();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
